// File: rtl/sfp_seq_ctrl.sv
// Sequencer for the SFP accumulate/ReLU stage: moves OFIFO rows into the SFP tiles for
// KIJ passes (or one pass), then drains the accumulated rows into the output SRAM.
module sfp_seq_ctrl #(
  parameter int COL    = 8,
  parameter int KIJ    = 9,
  parameter int NPIX   = 16,
  parameter int PIX_W  = $clog2(NPIX),
  parameter int KIJ_W  = $clog2(KIJ + 1),
  parameter int ADDR_W = 8,
  parameter int BASE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              execution_mode,
  input  logic [BASE_W-1:0] out_base,
  input  logic              ofifo_valid,
  input  logic              sfp_full,
  input  logic              sfp_valid,
  output logic              ofifo_rd,
  output logic [COL-1:0]    sfp_wr,
  output logic              out_wr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [KIJ_W-1:0]  kij_cnt,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_PASS_END,
    S_DRAIN,
    S_DONE
  } state_t;

  // The row counter must be able to hold NPIX itself, one more than the SRAM offset range.
  localparam int CNT_W = PIX_W + 1;
  localparam logic [CNT_W-1:0] ROWS     = CNT_W'(NPIX);
  localparam logic [KIJ_W-1:0] KIJ_LAST = KIJ_W'(KIJ - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    row_cnt_q, row_cnt_d;
  logic [KIJ_W-1:0]    kij_cnt_q, kij_cnt_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic                rd_q, rd_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    kij_cnt_d = kij_cnt_q;
    base_d    = base_q;
    rd_d      = 1'b0;
    ofifo_rd  = 1'b0;
    out_wr    = 1'b0;
    out_addr  = '0;
    done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d    = out_base;
          kij_cnt_d = '0;
          row_cnt_d = '0;
          state_d   = S_FILL;
        end
      end
      S_FILL: begin
        ofifo_rd = ofifo_valid & ~sfp_full & (row_cnt_q < ROWS);
        rd_d     = ofifo_rd;
        if (ofifo_rd) row_cnt_d = row_cnt_q + CNT_W'(1);
        // Leave only once the write for the last popped row has gone out.
        if (row_cnt_q == ROWS && !rd_q) state_d = S_PASS_END;
      end
      S_PASS_END: begin
        row_cnt_d = '0;
        if (execution_mode || kij_cnt_q == KIJ_LAST) begin
          state_d = S_DRAIN;
        end else begin
          kij_cnt_d = kij_cnt_q + KIJ_W'(1);
          state_d   = S_FILL;
        end
      end
      S_DRAIN: begin
        out_wr   = sfp_valid & (row_cnt_q < ROWS);
        out_addr = ADDR_W'(base_q) + ADDR_W'(row_cnt_q);
        if (out_wr) row_cnt_d = row_cnt_q + CNT_W'(1);
        if (row_cnt_q == ROWS) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; all flops, including
  // the latched base address, are cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      row_cnt_q <= '0;
      kij_cnt_q <= '0;
      base_q    <= '0;
      rd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      kij_cnt_q <= kij_cnt_d;
      base_q    <= base_d;
      rd_q      <= rd_d;
    end
  end

  // OFIFO read latency is one cycle, so the SFP write follows the pop by exactly one cycle.
  assign sfp_wr  = {COL{rd_q}};
  assign kij_cnt = kij_cnt_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_sfp_seq_ctrl.sv
// Self-checking bench for sfp_seq_ctrl: table of tile scenarios with randomized handshakes,
// checked against a transaction-level model, plus hand-written reset/abort sequences.
module tb_sfp_seq_ctrl;

  localparam int COL  = 8;
  localparam int KIJ  = 9;
  localparam int NPIX = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       execution_mode;
  logic [7:0] out_base;
  logic       ofifo_valid;
  logic       sfp_full;
  logic       sfp_valid;
  logic       ofifo_rd;
  logic [7:0] sfp_wr;
  logic       out_wr;
  logic [7:0] out_addr;
  logic [3:0] kij_cnt;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  sfp_seq_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .execution_mode (execution_mode),
    .out_base       (out_base),
    .ofifo_valid    (ofifo_valid),
    .sfp_full       (sfp_full),
    .sfp_valid      (sfp_valid),
    .ofifo_rd       (ofifo_rd),
    .sfp_wr         (sfp_wr),
    .out_wr         (out_wr),
    .out_addr       (out_addr),
    .kij_cnt        (kij_cnt),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  // valid_pat: 0 tied high, 1 toggling, 2 random. full_pat: 0 none, 1 3-cycle burst at
  // pass 2 row 5, 2 random. Expected counts come straight from KIJ/NPIX.
  typedef struct {
    logic       mode;
    logic [7:0] base;
    int         valid_pat;
    int         full_pat;
    int         sval_pct;
    bit         extra_start;
    int         exp_pops;
    int         exp_wrs;
    int         exp_kij;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ofifo_rd"}, ofifo_rd, 0);
    check({tag, "_sfp_wr"},   sfp_wr,   0);
    check({tag, "_out_wr"},   out_wr,   0);
    check({tag, "_out_addr"}, out_addr, 0);
    check({tag, "_kij_cnt"},  kij_cnt,  0);
    check({tag, "_busy"},     busy,     0);
    check({tag, "_done"},     done,     0);
  endtask

  // Runs one whole tile: starts it, drives handshakes cycle by cycle, and checks every
  // observable rule against a transaction-level view (pop/write counts, address list).
  task automatic run_tile(input vec_t v, input string tag);
    int  cyc = 0, pops = 0, wrs = 0, nout = 0, dones = 0, viol = 0;
    int  last_pop = -1, last_wr = -1, done_cyc = -1, full_left = 0, burst_wr = 0;
    int  exp_kij_now;
    bit  burst_done = 0, prev_rd = 0, finished = 0;

    execution_mode = v.mode;
    out_base       = v.base;
    ofifo_valid    = 1'b0;
    sfp_full       = 1'b0;
    sfp_valid      = 1'b0;
    start          = 1'b1;
    @(negedge clk);
    check({tag, "_idle_before_start"}, busy, 0);
    @(posedge clk);
    #1 start = 1'b0;

    while (!finished && cyc < 4000) begin
      cyc++;
      start = v.extra_start && (cyc == 20);
      case (v.valid_pat)
        0:       ofifo_valid = 1'b1;
        1:       ofifo_valid = (cyc % 2 == 1);
        default: ofifo_valid = ($urandom_range(0, 99) < 60);
      endcase
      if (v.full_pat == 1 && !burst_done && pops == 2 * NPIX + 5) begin
        full_left  = 3;
        burst_done = 1;
      end
      case (v.full_pat)
        1:       sfp_full = (full_left > 0);
        2:       sfp_full = ($urandom_range(0, 99) < 25);
        default: sfp_full = 1'b0;
      endcase
      sfp_valid = ($urandom_range(0, 99) < v.sval_pct);

      @(negedge clk);
      if (full_left > 0) begin
        if (sfp_wr == 8'hFF) burst_wr++;
        full_left--;
      end
      if (done_cyc >= 0) begin
        check({tag, "_busy_after_done"}, busy, 0);
        check({tag, "_done_single_cycle"}, done, 0);
        check({tag, "_kij_final"}, kij_cnt, v.exp_kij);
        finished = 1;
      end else begin
        if (!busy) viol++;
        if (ofifo_rd && !(ofifo_valid && !sfp_full)) viol++;
        if (ofifo_rd && out_wr) viol++;
        if (out_wr && !sfp_valid) viol++;
        if (sfp_wr != (prev_rd ? 8'hFF : 8'h00)) viol++;
        if (kij_cnt > KIJ - 1) viol++;
        if (sfp_wr == 8'hFF) wrs++;
        if (ofifo_rd) begin
          exp_kij_now = v.mode ? 0 : pops / NPIX;
          if (kij_cnt != exp_kij_now) viol++;
          if (v.valid_pat == 0 && v.full_pat == 0) begin
            if (pops == 0 && cyc != 1) viol++;
            if (pops > 0 && pops % NPIX == 0 && cyc - last_pop != 4) viol++;
          end
          pops++;
          last_pop = cyc;
        end
        if (out_wr) begin
          if (pops != v.exp_pops) viol++;
          check({tag, "_out_addr"}, out_addr, (v.base + nout) & 8'hFF);
          nout++;
          last_wr = cyc;
        end
        if (done) begin
          dones++;
          done_cyc = cyc;
          check({tag, "_done_latency"}, done_cyc - last_wr, 2);
        end
      end
      prev_rd = ofifo_rd;
      @(posedge clk);
      #1;
    end
    start = 1'b0;

    check({tag, "_completed"}, finished, 1);
    check({tag, "_pops"}, pops, v.exp_pops);
    check({tag, "_sfp_writes"}, wrs, v.exp_pops);
    check({tag, "_out_writes"}, nout, v.exp_wrs);
    check({tag, "_done_pulses"}, dones, 1);
    check({tag, "_rule_violations"}, viol, 0);
    if (v.full_pat == 1) begin
      check({tag, "_burst_seen"}, burst_done, 1);
      check({tag, "_pending_wr_in_burst"}, burst_wr, 1);
    end
  endtask

  // Aborts a tile with an asynchronous reset mid-FILL of pass 4, then checks a fresh run.
  task automatic reset_midrun();
    int pops = 0;
    int cyc  = 0;
    execution_mode = 1'b0;
    out_base       = 8'h55;
    ofifo_valid    = 1'b1;
    sfp_full       = 1'b0;
    sfp_valid      = 1'b0;
    start          = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (pops < 4 * NPIX + 7 && cyc < 2000) begin
      cyc++;
      @(negedge clk);
      if (ofifo_rd) pops++;
      if (pops < 4 * NPIX + 7) begin
        @(posedge clk);
        #1;
      end
    end
    check("abort_reached_pass4", pops, 4 * NPIX + 7);
    check("abort_kij_before_reset", kij_cnt, 4);
    check("abort_busy_before_reset", busy, 1);
    #2 reset = 1'b1;
    #1 check_all_zero("abort_async");
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_all_zero("abort_released");
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'h20, 0, 0, 100, 1'b0, KIJ * NPIX, NPIX, KIJ - 1};
    vecs[1] = '{1'b1, 8'h40, 0, 0, 100, 1'b0, NPIX,       NPIX, 0};
    vecs[2] = '{1'b0, 8'h10, 0, 1, 100, 1'b0, KIJ * NPIX, NPIX, KIJ - 1};
    vecs[3] = '{1'b0, 8'h33, 1, 0, 50,  1'b0, KIJ * NPIX, NPIX, KIJ - 1};
    vecs[4] = '{1'b0, 8'hF8, 0, 0, 70,  1'b0, KIJ * NPIX, NPIX, KIJ - 1};
    vecs[5] = '{1'b1, 8'hF8, 2, 2, 40,  1'b1, NPIX,       NPIX, 0};
    vecs[6] = '{1'b0, 8'h00, 2, 2, 60,  1'b1, KIJ * NPIX, NPIX, KIJ - 1};

    reset          = 1'b1;
    start          = 1'b0;
    execution_mode = 1'b0;
    out_base       = 8'h00;
    ofifo_valid    = 1'b0;
    sfp_full       = 1'b0;
    sfp_valid      = 1'b0;
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 7; i++) run_tile(vecs[i], $sformatf("v%0d", i));

    reset_midrun();
    run_tile(vecs[0], "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
